rsfq_splitter_tree_sync: RTL and testbench

- Clocked, parametrised successor to the two-way toggle-encoded RSFQ splitter model.
- Fans one toggle-encoded pulse input out to N_OUT toggle-encoded outputs.
- Adds three things the two-way model does not have: fixed splitter-tree latency, a minimum input pulse spacing (critical-time) check with drop-and-flag, and a per-output enable mask.
- Adds an arming delay after reset and observability counters.
- Used wherever a synchronous-domain fan-out model of an SFQ splitter tree is needed.

---
 rtl/rsfq_tree_pkg.sv | 18 +
 rtl/rsfq_pulse_pipe.sv | 36 +++
 rtl/rsfq_splitter_tree_sync.sv | 110 +++++++++++
 tb/tb_rsfq_splitter_tree_sync.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/rsfq_tree_pkg.sv
// Shared sizing helpers for the synchronous RSFQ splitter-tree model.
// Tree depth, pipeline latency and counter widths live here.
package rsfq_tree_pkg;

  function automatic int tree_levels(int n_out);
    return (n_out <= 2) ? 1 : $clog2(n_out);
  endfunction

  function automatic int tree_lat(int n_out, int stage_lat);
    return tree_levels(n_out) * stage_lat;
  endfunction

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_w(int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rsfq_pulse_pipe.sv
// Fixed-depth delay line carrying a valid bit and an output mask.
// Models the splitter-tree propagation delay; cleared asynchronously.
module rsfq_pulse_pipe #(
  parameter int N_OUT = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N_OUT-1:0] in_mask,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_mask
);

  logic [DEPTH-1:0] vld;
  logic [N_OUT-1:0] msk [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++)
        msk[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      msk[0] <= in_mask;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        msk[i] <= msk[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_mask  = msk[DEPTH-1];

endmodule

// File: rtl/rsfq_splitter_tree_sync.sv
// Clocked N-way toggle-encoded splitter tree with arming delay,
// critical-time drop-and-flag, per-output enable and counters.
module rsfq_splitter_tree_sync
  import rsfq_tree_pkg::*;
#(
  parameter int N_OUT      = 4,
  parameter int STAGE_LAT  = 1,
  parameter int CT_CYCLES  = 2,
  parameter int ARM_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [N_OUT-1:0] en,
  output logic [N_OUT-1:0] q,
  output logic             armed,
  output logic             viol,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int LAT = tree_lat(N_OUT, STAGE_LAT);
  localparam int GW  = cnt_w(CT_CYCLES);
  localparam int AW  = cnt_w(ARM_CYCLES);

  localparam logic [GW-1:0] CT_G  = GW'(CT_CYCLES);
  localparam logic [AW-1:0] ARM_L = AW'((ARM_CYCLES > 0) ? ARM_CYCLES - 1 : 0);

  logic             s_prev;
  logic [AW-1:0]    arm_cnt;
  logic             have_acc;
  logic [GW-1:0]    gap;
  logic             evt;
  logic             gap_ok;
  logic             accept;
  logic             drop;
  logic             pv;
  logic [N_OUT-1:0] pm;

  always_comb begin
    evt    = a ^ s_prev;
    gap_ok = !have_acc || (gap >= CT_G);
    accept = armed && evt && gap_ok;
    drop   = armed && evt && !gap_ok;
  end

  rsfq_pulse_pipe #(
    .N_OUT (N_OUT),
    .DEPTH (LAT)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_mask   (en),
    .out_valid (pv),
    .out_mask  (pm)
  );

  // History updates even while disarmed so a held level is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev  <= 1'b0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      s_prev <= a;
      if (!armed) begin
        arm_cnt <= arm_cnt + AW'(1);
        if (ARM_CYCLES <= 1 || arm_cnt == ARM_L)
          armed <= 1'b1;
      end
    end
  end

  // Gap counts edges since the last accepted event; drops do not restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_acc <= 1'b0;
      gap      <= '0;
    end else if (accept) begin
      have_acc <= 1'b1;
      gap      <= GW'(1);
    end else if (have_acc && gap < CT_G) begin
      gap <= gap + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= '0;
      viol_cnt <= '0;
      viol     <= 1'b0;
    end else begin
      viol <= drop;
      if (accept)
        acc_cnt <= acc_cnt + CNT_W'(1);
      if (drop && viol_cnt != '1)
        viol_cnt <= viol_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (pv)
      q <= q ^ pm;
  end

endmodule

// File: tb/tb_rsfq_splitter_tree_sync.sv
// Directed bench for rsfq_splitter_tree_sync: arming, fan-out, critical
// time, mask capture, reset in flight and small-counter saturation.
module tb_rsfq_splitter_tree_sync;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       a, a2;
  logic [3:0] en, en2;
  logic [3:0] q, q2;
  logic       armed, armed2;
  logic       viol, viol2;
  logic [7:0] acc_cnt, viol_cnt;
  logic [1:0] acc2, vc2;

  int tests = 0;
  int fails = 0;
  int e = 0;

  always #5 clk = ~clk;

  rsfq_splitter_tree_sync #(
    .N_OUT(4), .STAGE_LAT(1), .CT_CYCLES(2), .ARM_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .en(en), .q(q), .armed(armed),
    .viol(viol), .acc_cnt(acc_cnt), .viol_cnt(viol_cnt)
  );

  rsfq_splitter_tree_sync #(
    .N_OUT(4), .STAGE_LAT(1), .CT_CYCLES(2), .ARM_CYCLES(4), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .a(a2), .en(en2), .q(q2), .armed(armed2),
    .viol(viol2), .acc_cnt(acc2), .viol_cnt(vc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    a = 1'b0; a2 = 1'b0;
    en = 4'hf; en2 = 4'hf;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 4'h0);
    chk("rst_armed", armed, 1'b0);
    chk("rst_viol", viol, 1'b0);
    chk("rst_acc", acc_cnt, 8'd0);
    chk("rst_vcnt", viol_cnt, 8'd0);
    rst = 1'b0;
    e = 0;

    tick();
    a = 1'b1;
    tick();
    chk("arm_q2", q, 4'h0);
    chk("arm_acc2", acc_cnt, 8'd0);
    chk("arm_armed2", armed, 1'b0);
    run_to(3);
    chk("arm_armed3", armed, 1'b0);
    run_to(4);
    chk("arm_armed4", armed, 1'b1);
    run_to(9);
    chk("phantom_q", q, 4'h0);
    chk("phantom_acc", acc_cnt, 8'd0);
    chk("phantom_vcnt", viol_cnt, 8'd0);

    a = 1'b0;
    tick();
    chk("fan_acc10", acc_cnt, 8'd1);
    chk("fan_q10", q, 4'h0);
    tick();
    chk("fan_q11", q, 4'h0);
    tick();
    chk("fan_q12", q, 4'hf);
    run_to(14);
    a = 1'b1;
    tick();
    chk("fan_acc15", acc_cnt, 8'd2);
    run_to(16);
    chk("fan_q16", q, 4'hf);
    run_to(17);
    chk("fan_q17", q, 4'h0);

    run_to(19);
    a = 1'b0;
    tick();
    chk("ct_acc20", acc_cnt, 8'd3);
    chk("ct_viol20", viol, 1'b0);
    a = 1'b1;
    tick();
    chk("ct_viol21", viol, 1'b1);
    chk("ct_vcnt21", viol_cnt, 8'd1);
    chk("ct_acc21", acc_cnt, 8'd3);
    a = 1'b0;
    tick();
    chk("ct_viol22", viol, 1'b0);
    chk("ct_acc22", acc_cnt, 8'd4);
    chk("ct_q22", q, 4'hf);
    tick();
    chk("ct_q23", q, 4'hf);
    tick();
    chk("ct_q24", q, 4'h0);
    chk("ct_vcnt24", viol_cnt, 8'd1);

    run_to(29);
    a = 1'b1;
    en = 4'b0101;
    tick();
    en = 4'hf;
    tick();
    chk("mask_q31", q, 4'h0);
    tick();
    chk("mask_q32", q, 4'b0101);
    chk("mask_acc32", acc_cnt, 8'd5);

    run_to(39);
    a = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rif_q", q, 4'h0);
    chk("rif_armed", armed, 1'b0);
    chk("rif_acc", acc_cnt, 8'd0);
    chk("rif_vcnt", viol_cnt, 8'd0);
    tick();
    chk("rif_q42", q, 4'h0);
    rst = 1'b0;
    repeat (5) tick();
    chk("rif_q_after", q, 4'h0);
    chk("rif_acc_after", acc_cnt, 8'd0);

    rst2 = 1'b0;
    repeat (4) tick();
    chk("sat_armed", armed2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      a2 = ~a2;
      tick();
      if (i == 4) chk("sat_acc3", acc2, 2'd3);
      if (i == 5) chk("sat_vcnt3", vc2, 2'd3);
      if (i == 6) chk("sat_acc_wrap", acc2, 2'd0);
      if (i == 8) chk("sat_acc5", acc2, 2'd1);
      if (i == 9) chk("sat_vcnt_hold", vc2, 2'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
